// File: rtl/rssb_mem_responder.sv
// rssb_mem_responder: single-initiator memory-mapped responder.
//   Address 0 reads as zero, address 1 pops the input port, address 2 drives
//   the output port, addresses 3 and up are backed by an uninitialised RAM.
//   Each transaction spends WAIT_CYCLES wait states before a one-cycle ack.
// Optional feature: define RSSB_MEM_TIMEOUT_EN to bound the wait for input
//   data to 256 cycles; a timed-out read completes with rdata=0 and error=1.
module rssb_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              error
);

  localparam logic [3:0]        WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] A_ZERO  = '0;
  localparam logic [ADDR_W-1:0] A_IN    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_OUT   = ADDR_W'(2);

  typedef enum logic [1:0] {IDLE, WAIT, BLOCK, RESP} state_t;

  state_t              state_q;
  logic [3:0]          wcnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ack_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                cur_we;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic                need_in;
  logic                wait_done;
  logic                timeout_hit;
  logic                go_block;
  logic                go_resp;
  logic                ram_we;

`ifdef RSSB_MEM_TIMEOUT_EN
  logic [7:0]          bcnt_q;
  logic                err_q;

  // Timeout condition: the 256th consecutive BLOCK cycle ends without data.
  always_comb begin
    timeout_hit = (state_q == BLOCK) && !in_valid && (bcnt_q == 8'hFF);
  end

  // Count cycles spent in BLOCK; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= 8'd0;
    end else if (state_q == BLOCK) begin
      bcnt_q <= bcnt_q + 8'd1;
    end else begin
      bcnt_q <= 8'd0;
    end
  end

  assign error = err_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // Transaction fields and FSM decisions; in IDLE the live inputs are the
  // transaction, since with no wait states the accept edge is also the exit.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
    end
    need_in   = !cur_we && (cur_addr == A_IN) && !in_valid;
    wait_done = 1'b0;
    case (state_q)
      IDLE:    wait_done = req && (WAIT_LD == 4'd0);
      WAIT:    wait_done = (wcnt_q == 4'd1);
      default: wait_done = 1'b0;
    endcase
    go_block = wait_done && need_in;
    go_resp  = (wait_done && !need_in) ||
               ((state_q == BLOCK) && (in_valid || timeout_hit));
    ram_we   = go_resp && !rst && !timeout_hit && cur_we && (cur_addr > A_OUT);
  end

  // Capture the request fields at acceptance; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // RAM write lands on the edge that enters RESP, so an abort by reset
  // before that edge leaves memory untouched.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[cur_addr] <= cur_wdata;
    end
  end

  // Main FSM with registered strobes and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      ack_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rdata_q     <= '0;
      out_data_q  <= '0;
`ifdef RSSB_MEM_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      ack_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef RSSB_MEM_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req) begin
            wcnt_q <= WAIT_LD;
            if (WAIT_LD != 4'd0) begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_done) begin
            wcnt_q <= 4'd0;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: ;
      endcase

      if (go_block) begin
        state_q <= BLOCK;
      end

      if (go_resp) begin
        state_q <= RESP;
        ack_q   <= 1'b1;
        if (timeout_hit) begin
          rdata_q <= '0;
`ifdef RSSB_MEM_TIMEOUT_EN
          err_q   <= 1'b1;
`endif
        end else if (cur_we) begin
          if (cur_addr == A_OUT) begin
            out_data_q  <= cur_wdata;
            out_valid_q <= 1'b1;
          end
        end else if (cur_addr == A_ZERO) begin
          rdata_q <= '0;
        end else if (cur_addr == A_IN) begin
          rdata_q    <= in_data;
          in_ready_q <= 1'b1;
        end else if (cur_addr == A_OUT) begin
          rdata_q <= out_data_q;
        end else begin
          rdata_q <= mem[cur_addr];
        end
      end
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_rssb_mem_responder.sv
// Randomized self-checking bench for rssb_mem_responder against a
// transaction-level model (register map, RAM array, latency rule).
module tb_rssb_mem_responder;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int WC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          error;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m   [256];
  bit            known_m [256];
  logic [DW-1:0] out_m;

  always #5 clk = ~clk;

  rssb_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .error(error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transaction. For reads of the input port, d is the word offered and
  // raise_at is the cycle (0 = before accept, -1 = never) in_valid rises.
  task automatic do_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int raise_at, input bit expect_to);
    int          lat;
    int          exp_lat;
    bit          got;
    bit          is_in_rd;
    logic [DW-1:0] exp_rd;
    bit          rd_known;
    is_in_rd = !w && (a == 8'd1);
    req = 1'b1; we = w; addr = a; wdata = d;
    if (is_in_rd) begin
      in_valid = (raise_at == 0);
      in_data  = d;
    end else begin
      in_valid = 1'($urandom % 2);
      in_data  = DW'($urandom);
    end
    // Ack comes one cycle after both the wait states and the input word.
    if (is_in_rd && expect_to) exp_lat = WC + 1 + 256;
    else if (is_in_rd)         exp_lat = ((raise_at > WC) ? raise_at : WC) + 1;
    else                       exp_lat = WC + 1;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 600) begin
      @(negedge clk);
      lat++;
      if (ack) begin
        got = 1'b1;
      end else begin
        chk("idle_strobes", {ack, in_ready, out_valid, error}, 4'b0);
        if (is_in_rd && lat == raise_at) begin
          in_valid = 1'b1;
          in_data  = d;
        end
      end
    end
    chk("ack_seen", got, 1);
    if (got) begin
      chk("latency", lat, exp_lat);
      rd_known = 1'b1;
      if (a == 8'd0)      exp_rd = '0;
      else if (a == 8'd1) exp_rd = expect_to ? '0 : d;
      else if (a == 8'd2) exp_rd = out_m;
      else begin
        exp_rd   = mem_m[a];
        rd_known = known_m[a];
      end
      if (!w && rd_known) chk("rdata", rdata, exp_rd);
      chk("in_ready", in_ready, is_in_rd && !expect_to);
      chk("out_valid", out_valid, w && (a == 8'd2));
      chk("error", error, expect_to);
      if (w && a == 8'd2) out_m = d;
      if (w && a >= 8'd3) begin
        mem_m[a]   = d;
        known_m[a] = 1'b1;
      end
      chk("out_data", out_data, out_m);
    end
    req = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_ack", {ack, in_ready, out_valid, error}, 4'b0);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    in_valid = 1'b0; in_data = '0; out_m = '0;
    for (int i = 0; i < 256; i++) known_m[i] = 1'b0;
    #1 rst = 1'b1;
    #1 chk("reset_outs", {ack, in_ready, out_valid, error, rdata, out_data}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed scenarios
    do_txn(1'b1, 8'd5, 16'h1234, 0, 1'b0);
    do_txn(1'b0, 8'd5, 16'h0000, 0, 1'b0);
    chk("rd5_value", rdata, 16'h1234);
    do_txn(1'b1, 8'd2, 16'hBEEF, 0, 1'b0);
    do_txn(1'b0, 8'd2, 16'h0000, 0, 1'b0);
    chk("rd2_value", rdata, 16'hBEEF);
    do_txn(1'b1, 8'd0, 16'hFFFF, 0, 1'b0);
    do_txn(1'b0, 8'd0, 16'h0000, 0, 1'b0);
    do_txn(1'b0, 8'd1, 16'h00A5, 10, 1'b0);
    do_txn(1'b0, 8'd1, 16'h5C3A, 0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      int            r;
      bit            w;
      logic [AW-1:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 3)      a = AW'(r);
      else if (r < 9) a = AW'(3 + $urandom_range(0, 5));
      else            a = AW'($urandom);
      w = 1'($urandom % 2);
      do_txn(w, a, DW'($urandom), int'($urandom_range(0, 6)), 1'b0);
    end

    // Reset in the middle of a write to address 7
    do_txn(1'b1, 8'd7, 16'h5A5A, 0, 1'b0);
    req = 1'b1; we = 1'b1; addr = 8'd7; wdata = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_async", {ack, in_ready, out_valid, error, rdata, out_data}, 64'd0);
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold", {ack, in_ready, out_valid, error, rdata, out_data}, 64'd0);
    end
    rst = 1'b0;
    out_m = '0;
    @(negedge clk);
    chk("after_rst", {ack, in_ready, out_valid, error}, 4'b0);
    do_txn(1'b0, 8'd7, 16'h0000, 0, 1'b0);
    chk("rd7_kept", rdata, 16'h5A5A);

`ifdef RSSB_MEM_TIMEOUT_EN
    do_txn(1'b0, 8'd1, 16'h7777, -1, 1'b1);
    do_txn(1'b0, 8'd1, 16'h1111, 3, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rssb_mem_responder.md
RSSB_MEM_RESPONDER -- requirements
Module: rssb_mem_responder

Interface
REQ-001 Parameter ADDR_W, 8, word-address width; RAM depth 2**ADDR_W words.
REQ-002 Parameter DATA_W, 16, data word width.
REQ-003 Parameter WAIT_CYCLES, 1, wait states inserted before each response; legal range 0..15.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  1  initiator request; held high until ack.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  ADDR_W  word address; sampled with req.
REQ-009 wdata  input  DATA_W  write data; sampled with req.
REQ-010 ack  output  1  one-cycle completion pulse.
REQ-011 rdata  output  DATA_W  read data; valid while ack=1, holds until next ack.
REQ-012 in_valid  input  1  input port has a word.
REQ-013 in_data  input  DATA_W  input port word.
REQ-014 in_ready  output  1  one-cycle pop of input port.
REQ-015 out_valid  output  1  one-cycle push strobe on output port.
REQ-016 out_data  output  DATA_W  last word written to OUT; holds between writes.
REQ-017 error  output  1  one-cycle flag, coincident with ack, for timed-out read (see Configuration).

Function
REQ-018 FSM states IDLE, WAIT, BLOCK, RESP; encoding free.
REQ-019 IDLE: req=1 at an edge latches we/addr/wdata and moves to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-020 WAIT: down-counter loaded with WAIT_CYCLES at accept; leaves WAIT when counter reaches 1.
REQ-021 WAIT exit: read of address 1 with in_valid=0 goes to BLOCK; all others go to RESP.
REQ-022 BLOCK: stays until in_valid=1, then goes to RESP.
REQ-023 RESP: ack=1 for exactly one cycle, then IDLE; a new req is sampled no earlier than the IDLE cycle after RESP.
REQ-024 Latency without blocking: ack high in cycle WAIT_CYCLES+1 after the accepting edge (WAIT_CYCLES=0 -> next cycle).
REQ-025 Address 0 (ZERO): read returns 0; write discarded.
REQ-026 Address 1 (IN): read returns in_data, in_ready=1 in the RESP cycle; write discarded.
REQ-027 Address 2 (OUT): write updates out_data, out_valid=1 in the RESP cycle; read returns current out_data.
REQ-028 Addresses 3..2**ADDR_W-1: RAM; write stores wdata in the RESP cycle; read returns stored word.
REQ-029 Reads of unwritten RAM locations return an unspecified value; no RAM initialisation.
REQ-030 req dropping before ack is a protocol violation; the transaction still completes.
REQ-031 ack, in_ready, out_valid, error never assert outside RESP.

Reset
REQ-032 rst=1 forces IDLE, counters 0, ack=0, in_ready=0, out_valid=0, error=0, rdata=0, out_data=0, immediately and regardless of clk.
REQ-033 Reset mid-transaction aborts it: no ack, no RAM write, no port strobe after rst rises.
REQ-034 First request accepted at the first clk edge with rst=0 and req=1.

Configuration
REQ-035 Macro RSSB_MEM_TIMEOUT_EN defined: BLOCK counts cycles; after 256 consecutive cycles in BLOCK, goes to RESP with rdata=0, error=1, in_ready=0.
REQ-036 Macro RSSB_MEM_TIMEOUT_EN undefined: BLOCK waits indefinitely; error tied to 0.

Verification
REQ-037 WAIT_CYCLES=1: write 0x1234 to addr 5, then read addr 5 -> each ack exactly 2 cycles after accept; read rdata=0x1234.
REQ-038 Write 0xBEEF to addr 2 -> out_valid pulse 1 cycle, out_data=0xBEEF; subsequent read of addr 2 -> rdata=0xBEEF.
REQ-039 Write 0xFFFF to addr 0, read addr 0 -> rdata=0x0000.
REQ-040 Read addr 1 with in_valid=0, raise in_valid with in_data=0x00A5 after 10 cycles -> ack and in_ready in the same cycle one cycle after in_valid=1; rdata=0x00A5.
REQ-041 Assert rst during WAIT of a write to addr 7 -> no ack; addr 7 unchanged on later read; all outputs 0 during rst.
REQ-042 RSSB_MEM_TIMEOUT_EN defined, read addr 1 with in_valid held 0 -> after 256 BLOCK cycles ack=1, error=1, rdata=0, in_ready=0.
